// File: rtl/camera_sync_pkg.sv
// Shared types for the master/slave camera synchroniser.
// Holds FSM state encodings, the skew count type and its saturation value.
package camera_sync_pkg;

    typedef logic [7:0] count_t;

    localparam count_t SAT_COUNT = 8'd255;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_CNT_M,
        MS_CNT_S,
        MS_DONE
    } meas_state_t;

    typedef enum logic [2:0] {
        MA_WAIT_READY,
        MA_WAIT_ADC,
        MA_DELAY,
        MA_RST,
        MA_SAMPLE,
        MA_WAIT_ACK
    } master_state_t;

    typedef enum logic [2:0] {
        SL_IDLE,
        SL_ARMED,
        SL_RST,
        SL_SAMPLE,
        SL_RELEASE
    } slave_state_t;

    // Falling edge from a registered previous/current pair.
    function automatic logic fell(input logic prev, input logic cur);
        return prev & ~cur;
    endfunction

endpackage

// File: rtl/skew_measure.sv
// Edge detectors for both ADC status pins plus the one-shot skew measurement.
// Ports: i_clk/i_rst, the two end_adc pins; outputs the falling-edge strobes,
// the registered slave level, and the latched skew (o_mismatch_delay,
// o_slave_leads, o_ready).
module skew_measure
    import camera_sync_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_master_end_adc,
    input  logic   i_slave_end_adc,
    output logic   o_master_fall,
    output logic   o_slave_fall,
    output logic   o_slave_level,
    output count_t o_mismatch_delay,
    output logic   o_slave_leads,
    output logic   o_ready
);

    logic        r_m_cur;
    logic        r_m_prev;
    logic        r_s_cur;
    logic        r_s_prev;
    meas_state_t r_state;
    count_t      r_cnt;
    count_t      r_mis;
    logic        r_leads;
    logic        r_ready;

    logic        w_m_fall;
    logic        w_s_fall;
    logic        w_other_fall;

    // Pipes clear to 0 so a pin already low at reset release never
    // looks like a falling edge.
    assign w_m_fall = fell(r_m_prev, r_m_cur);
    assign w_s_fall = fell(r_s_prev, r_s_cur);

    // While counting, only the lagging camera's edge ends the measurement.
    assign w_other_fall = (r_state == MS_CNT_M) ? w_s_fall : w_m_fall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m_cur  <= 1'b0;
            r_m_prev <= 1'b0;
            r_s_cur  <= 1'b0;
            r_s_prev <= 1'b0;
            r_state  <= MS_IDLE;
            r_cnt    <= '0;
            r_mis    <= '0;
            r_leads  <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_m_cur  <= i_master_end_adc;
            r_m_prev <= r_m_cur;
            r_s_cur  <= i_slave_end_adc;
            r_s_prev <= r_s_cur;

            unique case (r_state)
                MS_IDLE: begin
                    if (w_m_fall && w_s_fall) begin
                        r_mis   <= '0;
                        r_leads <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= MS_DONE;
                    end else if (w_m_fall) begin
                        r_cnt   <= '0;
                        r_state <= MS_CNT_M;
                    end else if (w_s_fall) begin
                        r_cnt   <= '0;
                        r_state <= MS_CNT_S;
                    end
                end
                MS_CNT_M, MS_CNT_S: begin
                    if (w_other_fall) begin
                        r_mis   <= r_cnt + 8'd1;
                        r_leads <= (r_state == MS_CNT_S);
                        r_ready <= 1'b1;
                        r_state <= MS_DONE;
                    end else if (r_cnt == SAT_COUNT - 8'd1) begin
                        // Other camera never answered; report full scale.
                        r_mis   <= SAT_COUNT;
                        r_leads <= (r_state == MS_CNT_S);
                        r_ready <= 1'b1;
                        r_state <= MS_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                MS_DONE: begin
                    r_state <= MS_DONE;
                end
                default: r_state <= MS_IDLE;
            endcase
        end
    end

    assign o_master_fall    = w_m_fall;
    assign o_slave_fall     = w_s_fall;
    assign o_slave_level    = r_s_cur;
    assign o_mismatch_delay = r_mis;
    assign o_slave_leads    = r_leads;
    assign o_ready          = r_ready;

endmodule

// File: rtl/camera_sync_core.sv
// Master/slave image sensor synchroniser on a single pixel clock.
// Ports: pix_clk/rst_FSM; master/slave end_adc status pins; open-drain drives
// sync_req_n_o/ack_n_o with resolved levels sync_req_n_i/ack_n_i; camera
// rst/sample pulses; measured skew (mismatch_delay, slave_leads, ready).
module camera_sync_core
    import camera_sync_pkg::*;
#(
    parameter int RST_CYCLES    = 4,
    parameter int SAMPLE_CYCLES = 2,
    parameter int ACK_TIMEOUT   = 32
) (
    input  logic       pix_clk,
    input  logic       rst_FSM,
    input  logic       master_end_adc,
    input  logic       slave_end_adc,
    output logic       sync_req_n_o,
    input  logic       sync_req_n_i,
    output logic       ack_n_o,
    input  logic       ack_n_i,
    output logic       master_rst_cam,
    output logic       master_sample_cam,
    output logic       slave_rst_cam,
    output logic       slave_sample_cam,
    output logic [7:0] mismatch_delay,
    output logic       slave_leads,
    output logic       ready
);

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [3:0]      RST_LAST = 4'(RST_CYCLES - 1);
    localparam logic [3:0]      SMP_LAST = 4'(SAMPLE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

    logic   w_m_fall;
    logic   w_s_fall;
    logic   w_s_level;
    count_t w_mis;
    logic   w_leads;
    logic   w_ready;
    count_t w_delay;

    logic r_req_q;
    logic r_ack_q;

    master_state_t   r_m_state;
    logic            r_m_rst;
    logic            r_m_smp;
    logic            r_req_n;
    logic [TO_W-1:0] r_to;
    logic [3:0]      r_m_cnt;
    count_t          r_dly;

    slave_state_t r_s_state;
    logic         r_s_rst;
    logic         r_s_smp;
    logic         r_ack_n;
    logic [3:0]   r_s_cnt;

    skew_measure u_skew (
        .i_clk            (pix_clk),
        .i_rst            (rst_FSM),
        .i_master_end_adc (master_end_adc),
        .i_slave_end_adc  (slave_end_adc),
        .o_master_fall    (w_m_fall),
        .o_slave_fall     (w_s_fall),
        .o_slave_level    (w_s_level),
        .o_mismatch_delay (w_mis),
        .o_slave_leads    (w_leads),
        .o_ready          (w_ready)
    );

    // A leading slave gets no extra wait; the master only delays
    // when it is the early camera.
    assign w_delay = w_leads ? '0 : w_mis;

    // Bus levels resolve off-chip; register them before use.
    always_ff @(posedge pix_clk) begin
        if (rst_FSM) begin
            r_req_q <= 1'b1;
            r_ack_q <= 1'b1;
        end else begin
            r_req_q <= sync_req_n_i;
            r_ack_q <= ack_n_i;
        end
    end

    always_ff @(posedge pix_clk) begin
        if (rst_FSM) begin
            r_m_state <= MA_WAIT_READY;
            r_m_rst   <= 1'b0;
            r_m_smp   <= 1'b0;
            r_req_n   <= 1'b1;
            r_to      <= '0;
            r_m_cnt   <= '0;
            r_dly     <= '0;
        end else begin
            // Request runs independently of the pulse phases: it ends
            // on ack or on timeout, whichever comes first.
            if (!r_req_n) begin
                if (!r_ack_q || r_to == TO_LAST) begin
                    r_req_n <= 1'b1;
                end else begin
                    r_to <= r_to + 1'b1;
                end
            end

            unique case (r_m_state)
                MA_WAIT_READY: begin
                    if (w_ready) begin
                        r_m_state <= MA_WAIT_ADC;
                    end
                end
                MA_WAIT_ADC: begin
                    if (w_m_fall) begin
                        if (w_delay == '0) begin
                            r_m_state <= MA_RST;
                            r_m_rst   <= 1'b1;
                            r_m_cnt   <= '0;
                            r_req_n   <= 1'b0;
                            r_to      <= '0;
                        end else begin
                            r_dly     <= w_delay;
                            r_m_state <= MA_DELAY;
                        end
                    end
                end
                MA_DELAY: begin
                    if (r_dly == 8'd1) begin
                        r_m_state <= MA_RST;
                        r_m_rst   <= 1'b1;
                        r_m_cnt   <= '0;
                        r_req_n   <= 1'b0;
                        r_to      <= '0;
                    end else begin
                        r_dly <= r_dly - 8'd1;
                    end
                end
                MA_RST: begin
                    if (r_m_cnt == RST_LAST) begin
                        r_m_rst   <= 1'b0;
                        r_m_smp   <= 1'b1;
                        r_m_cnt   <= '0;
                        r_m_state <= MA_SAMPLE;
                    end else begin
                        r_m_cnt <= r_m_cnt + 4'd1;
                    end
                end
                MA_SAMPLE: begin
                    if (r_m_cnt == SMP_LAST) begin
                        r_m_smp   <= 1'b0;
                        r_m_state <= MA_WAIT_ACK;
                    end else begin
                        r_m_cnt <= r_m_cnt + 4'd1;
                    end
                end
                MA_WAIT_ACK: begin
                    if (r_req_n) begin
                        r_m_state <= MA_WAIT_ADC;
                    end
                end
                default: r_m_state <= MA_WAIT_READY;
            endcase
        end
    end

    always_ff @(posedge pix_clk) begin
        if (rst_FSM) begin
            r_s_state <= SL_IDLE;
            r_s_rst   <= 1'b0;
            r_s_smp   <= 1'b0;
            r_ack_n   <= 1'b1;
            r_s_cnt   <= '0;
        end else begin
            unique case (r_s_state)
                SL_IDLE: begin
                    if (w_s_fall) begin
                        r_s_state <= SL_ARMED;
                    end
                end
                SL_ARMED: begin
                    if (!r_req_q) begin
                        r_s_state <= SL_RST;
                        r_s_rst   <= 1'b1;
                        r_ack_n   <= 1'b0;
                        r_s_cnt   <= '0;
                    end else if (w_s_level) begin
                        // Conversion ended without a request; stand down.
                        r_s_state <= SL_IDLE;
                    end
                end
                SL_RST: begin
                    if (r_s_cnt == RST_LAST) begin
                        r_s_rst   <= 1'b0;
                        r_s_smp   <= 1'b1;
                        r_s_cnt   <= '0;
                        r_s_state <= SL_SAMPLE;
                    end else begin
                        r_s_cnt <= r_s_cnt + 4'd1;
                    end
                end
                SL_SAMPLE: begin
                    if (r_s_cnt == SMP_LAST) begin
                        r_s_smp   <= 1'b0;
                        r_s_state <= SL_RELEASE;
                    end else begin
                        r_s_cnt <= r_s_cnt + 4'd1;
                    end
                end
                SL_RELEASE: begin
                    if (r_req_q) begin
                        r_ack_n   <= 1'b1;
                        r_s_state <= SL_IDLE;
                    end
                end
                default: r_s_state <= SL_IDLE;
            endcase
        end
    end

    assign sync_req_n_o      = r_req_n;
    assign ack_n_o           = r_ack_n;
    assign master_rst_cam    = r_m_rst;
    assign master_sample_cam = r_m_smp;
    assign slave_rst_cam     = r_s_rst;
    assign slave_sample_cam  = r_s_smp;
    assign mismatch_delay    = w_mis;
    assign slave_leads       = w_leads;
    assign ready             = w_ready;

endmodule

// File: tb/tb_camera_sync_core.sv
// Directed bench for camera_sync_core: skew measurement cases, a full
// master/slave exchange with delayed ack loopback, ack timeout, and reset.
module tb_camera_sync_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_adc;
    logic       s_adc;
    logic       sync_o;
    logic       sync_i;
    logic       ack_o;
    logic       ack_i;
    logic       m_rst;
    logic       m_smp;
    logic       s_rst;
    logic       s_smp;
    logic [7:0] mis;
    logic       leads;
    logic       rdy;

    logic ack_d1 = 1'b1;
    logic ack_d2 = 1'b1;
    logic ack_block;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    // Wired-AND buses: request is seen at once, ack after two cycles.
    assign sync_i = sync_o;
    assign ack_i  = ack_d2 | ack_block;

    always @(posedge clk) begin
        ack_d1 <= ack_o;
        ack_d2 <= ack_d1;
    end

    camera_sync_core dut (
        .pix_clk           (clk),
        .rst_FSM           (rst),
        .master_end_adc    (m_adc),
        .slave_end_adc     (s_adc),
        .sync_req_n_o      (sync_o),
        .sync_req_n_i      (sync_i),
        .ack_n_o           (ack_o),
        .ack_n_i           (ack_i),
        .master_rst_cam    (m_rst),
        .master_sample_cam (m_smp),
        .slave_rst_cam     (s_rst),
        .slave_sample_cam  (s_smp),
        .mismatch_delay    (mis),
        .slave_leads       (leads),
        .ready             (rdy)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {m_rst, m_smp, sync_o, s_rst, s_smp, ack_o} after each edge.
    logic [5:0] seq_exp [14] = '{
        6'b001001, 6'b001001, 6'b001001, 6'b100001,
        6'b100001, 6'b100100, 6'b100100, 6'b010100,
        6'b010100, 6'b001010, 6'b001010, 6'b001000,
        6'b001001, 6'b001001
    };

    initial begin
        rst       = 1'b1;
        m_adc     = 1'b1;
        s_adc     = 1'b1;
        ack_block = 1'b0;
        tick(2);
        check("rst_sync", {7'd0, sync_o}, 8'd1);
        check("rst_ack", {7'd0, ack_o}, 8'd1);
        check("rst_pulses", {4'd0, m_rst, m_smp, s_rst, s_smp}, 8'd0);
        check("rst_mis", mis, 8'd0);
        check("rst_leads", {7'd0, leads}, 8'd0);
        check("rst_ready", {7'd0, rdy}, 8'd0);
        rst = 1'b0;

        // Master leads by 2.
        tick(28);
        m_adc = 1'b0;
        tick(2);
        check("m2_no_pulse", {6'd0, m_rst, s_rst}, 8'd0);
        s_adc = 1'b0;
        tick(1);
        check("m2_ready_early", {7'd0, rdy}, 8'd0);
        tick(1);
        check("m2_ready", {7'd0, rdy}, 8'd1);
        check("m2_mis", mis, 8'd2);
        check("m2_leads", {7'd0, leads}, 8'd0);
        check("m2_no_pulse2", {6'd0, m_rst, s_rst}, 8'd0);

        // Full exchange with delay 2 and ack looped back.
        m_adc = 1'b1;
        s_adc = 1'b1;
        tick(3);
        m_adc = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            check($sformatf("seq[%0d]", i + 1),
                  {2'b00, m_rst, m_smp, sync_o, s_rst, s_smp, ack_o},
                  {2'b00, seq_exp[i]});
            if (i == 1) s_adc = 1'b0;
        end

        // Ack never arrives: request times out after 32 cycles.
        ack_block = 1'b1;
        m_adc = 1'b1;
        s_adc = 1'b1;
        tick(3);
        m_adc = 1'b0;
        tick(4);
        check("to_start", {7'd0, sync_o}, 8'd0);
        tick(31);
        check("to_hold", {7'd0, sync_o}, 8'd0);
        tick(1);
        check("to_release", {7'd0, sync_o}, 8'd1);
        check("to_no_ack", {7'd0, ack_o}, 8'd1);

        // Back in WAIT_ADC: new edge, then reset during RST.
        m_adc = 1'b1;
        tick(3);
        m_adc = 1'b0;
        tick(5);
        check("mid_rst_on", {7'd0, m_rst}, 8'd1);
        check("mid_sync_low", {7'd0, sync_o}, 8'd0);
        rst = 1'b1;
        tick(1);
        check("rst_mid_pulses", {4'd0, m_rst, m_smp, s_rst, s_smp}, 8'd0);
        check("rst_mid_sync", {7'd0, sync_o}, 8'd1);
        check("rst_mid_ready", {7'd0, rdy}, 8'd0);
        check("rst_mid_mis", mis, 8'd0);
        rst   = 1'b0;
        m_adc = 1'b1;

        // Slave leads by 5.
        tick(3);
        s_adc = 1'b0;
        tick(5);
        m_adc = 1'b0;
        tick(1);
        check("s5_ready_early", {7'd0, rdy}, 8'd0);
        tick(1);
        check("s5_ready", {7'd0, rdy}, 8'd1);
        check("s5_mis", mis, 8'd5);
        check("s5_leads", {7'd0, leads}, 8'd1);

        // Simultaneous edges.
        rst = 1'b1;
        tick(1);
        check("sim_rst_leads", {7'd0, leads}, 8'd0);
        rst   = 1'b0;
        m_adc = 1'b1;
        s_adc = 1'b1;
        tick(3);
        m_adc = 1'b0;
        s_adc = 1'b0;
        tick(1);
        check("sim_ready_early", {7'd0, rdy}, 8'd0);
        tick(1);
        check("sim_ready", {7'd0, rdy}, 8'd1);
        check("sim_mis", mis, 8'd0);
        check("sim_leads", {7'd0, leads}, 8'd0);

        // Slave never falls: saturates at 255.
        rst = 1'b1;
        tick(1);
        check("sat_rst_ready", {7'd0, rdy}, 8'd0);
        rst   = 1'b0;
        m_adc = 1'b1;
        s_adc = 1'b1;
        tick(3);
        m_adc = 1'b0;
        tick(256);
        check("sat_ready_early", {7'd0, rdy}, 8'd0);
        tick(1);
        check("sat_ready", {7'd0, rdy}, 8'd1);
        check("sat_mis", mis, 8'd255);
        check("sat_leads", {7'd0, leads}, 8'd0);
        tick(40);
        check("sat_hold", mis, 8'd255);
        check("sat_hold_ready", {7'd0, rdy}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
